reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width; register count is 2**ADDR_W.
REQ-002 Parameter LOAD_LAT, default 1: cycles after issue before a load result is forwardable.
REQ-003 Parameter ALU_LAT, default 0: cycles after issue before a non-load result is forwardable.
REQ-004 Parameter CNT_W, default 2: per-register countdown width; must hold max(LOAD_LAT, ALU_LAT).
REQ-005 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 issue_valid  in  1  ID holds a valid instruction.
REQ-007 op  in  INST_OP_BUS  primary opcode; rs, rt, rd  in  ADDR_W  instruction register fields.
REQ-008 flush  in  1  pipeline flush (branch/jump redirect).
REQ-009 reg_read_en_1, reg_read_en_2  out  1  read-port enables; reg_addr_1, reg_addr_2  out  ADDR_W  read addresses.
REQ-010 reg_write_en  out  1, reg_write_addr  out  ADDR_W  destination of the ID instruction.
REQ-011 stall  out  1  ID instruction must be held this cycle.
REQ-012 issue  out  1  instruction accepted this cycle = issue_valid & ~stall & ~flush.

Function
REQ-013 Decode is combinational. ADDIU/ADDI/ANDI/ORI/LB/LW/LBU read rs on port 1 only; BEQ/BNE/SB/SW/SPECIAL read rs on port 1 and rt on port 2; all other opcodes read nothing; a disabled port drives address 0.
REQ-014 Writes: ADDIU/ADDI/ANDI/ORI/LUI/LB/LBU/LW write rt; SPECIAL writes rd; JAL writes 31; all other opcodes have write enable 0 and address 0.
REQ-015 Per register r, a countdown cnt[r] of CNT_W bits; r is pending while cnt[r] != 0.
REQ-016 stall = issue_valid & ((reg_read_en_1 & cnt[reg_addr_1]!=0) | (reg_read_en_2 & cnt[reg_addr_2]!=0)), combinational, same cycle.
REQ-017 Each rising edge, every nonzero cnt decrements by 1, saturating at 0.
REQ-018 On issue with reg_write_en and reg_write_addr != 0, cnt[reg_write_addr] loads LOAD_LAT for LB/LBU/LW, otherwise ALU_LAT; the load takes priority over the decrement of that entry.
REQ-019 cnt[0] is constant 0; register 0 is never pending, and reading it never stalls.
REQ-020 Flush clears every cnt to 0 on the next edge and suppresses issue in the same cycle; flush takes priority over issue.
REQ-021 An instruction that reads its own destination stalls only on the old pending state; its own write does not stall it.
REQ-022 stall is independent of flush; issue is never asserted while stall or flush is high.

Reset
REQ-023 Assertion of rst_n low asynchronously clears all cnt entries to 0 (and the stall counter, when present).
REQ-024 During and after reset, with issue_valid=0, stall=0 and issue=0; decode outputs follow the inputs combinationally.
REQ-025 Reset deassertion mid-stream: the first edge after release behaves as with an empty scoreboard.

Configuration
REQ-026 With macro REG_SB_STAT_EN defined, output stall_cycles (32 bits) counts cycles in which stall=1, saturating at 0xFFFFFFFF and cleared only by reset.
REQ-027 Without REG_SB_STAT_EN, the stall_cycles port and its counter do not exist; all other behaviour is identical.

Structure
REQ-028 Opcode constants come from the shared opcode definitions; INST_OP_BUS and REG_ADDR_BUS come from the shared bus definitions; no new opcode values are defined locally.
REQ-029 Decode (REQ-013/014) is a combinational sub-module reg_decode, parametrised by ADDR_W; reg_scoreboard instantiates it and holds all state.

Verification
REQ-030 Reset then idle: rst_n=0 for 3 cycles, then 1 with issue_valid=0 -> stall=0, issue=0, all cnt 0.
REQ-031 Load-use: LW rt=8 issued at cycle 0, then ADDU rs=8 valid at cycle 1 (LOAD_LAT=1) -> stall=1 at cycle 1, issue=1 at cycle 2.
REQ-032 ALU back-to-back: ADDIU rt=9, then BEQ rs=9 rt=9 (ALU_LAT=0) -> no stall; issue on consecutive cycles.
REQ-033 Register 0: LW rt=0, then SW rs=0 rt=0 -> no stall; JAL, then ADDU rs=31 with ALU_LAT=1 -> one stall cycle.
REQ-034 Flush: LW rt=5 issued, flush=1 next cycle, then ADDU rs=5 -> no stall after flush; issue=0 during the flush cycle.
REQ-035 Stats (REG_SB_STAT_EN defined): 3 load-use stalls -> stall_cycles=3; async reset mid-stall -> stall_cycles=0 and stall=0 immediately.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared opcode and bus definitions for the ID-stage register scoreboard.
// Opcode values follow the MIPS-I primary opcode map.
package reg_scoreboard_pkg;

   localparam int unsigned INST_OP_BUS_W  = 6;
   localparam int unsigned REG_ADDR_BUS_W = 5;
   localparam int unsigned LINK_REG       = 31;

   typedef logic [INST_OP_BUS_W-1:0]  inst_op_bus_t;
   typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

   typedef enum logic [INST_OP_BUS_W-1:0] {
      OP_SPECIAL = 6'b000000,
      OP_J       = 6'b000010,
      OP_JAL     = 6'b000011,
      OP_BEQ     = 6'b000100,
      OP_BNE     = 6'b000101,
      OP_ADDI    = 6'b001000,
      OP_ADDIU   = 6'b001001,
      OP_ANDI    = 6'b001100,
      OP_ORI     = 6'b001101,
      OP_LUI     = 6'b001111,
      OP_LB      = 6'b100000,
      OP_LW      = 6'b100011,
      OP_LBU     = 6'b100100,
      OP_SB      = 6'b101000,
      OP_SW      = 6'b101011
   } inst_op_e;

endpackage

// File: rtl/reg_scoreboard_decode.sv
// Combinational register-usage decode: which GPRs the ID instruction reads
// and writes, plus whether its result comes from a load.
module reg_decode
   import reg_scoreboard_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic [INST_OP_BUS_W-1:0] op,
   input  logic [ADDR_W-1:0]        rs,
   input  logic [ADDR_W-1:0]        rt,
   input  logic [ADDR_W-1:0]        rd,
   output logic                     reg_read_en_1,
   output logic                     reg_read_en_2,
   output logic [ADDR_W-1:0]        reg_addr_1,
   output logic [ADDR_W-1:0]        reg_addr_2,
   output logic                     reg_write_en,
   output logic [ADDR_W-1:0]        reg_write_addr,
   output logic                     is_load
);

   always_comb begin
      reg_read_en_1 = 1'b0;
      reg_read_en_2 = 1'b0;
      case (op)
         OP_ADDIU, OP_ADDI, OP_ANDI, OP_ORI, OP_LB, OP_LW, OP_LBU: begin
            reg_read_en_1 = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_SB, OP_SW, OP_SPECIAL: begin
            reg_read_en_1 = 1'b1;
            reg_read_en_2 = 1'b1;
         end
         default: begin
            reg_read_en_1 = 1'b0;
            reg_read_en_2 = 1'b0;
         end
      endcase
   end

   // Disabled ports read r0 so the hazard lookup can never see a pending entry.
   assign reg_addr_1 = reg_read_en_1 ? rs : '0;
   assign reg_addr_2 = reg_read_en_2 ? rt : '0;

   always_comb begin
      reg_write_en   = 1'b0;
      reg_write_addr = '0;
      is_load        = 1'b0;
      case (op)
         OP_ADDIU, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
            reg_write_en   = 1'b1;
            reg_write_addr = rt;
         end
         OP_LB, OP_LBU, OP_LW: begin
            reg_write_en   = 1'b1;
            reg_write_addr = rt;
            is_load        = 1'b1;
         end
         OP_SPECIAL: begin
            reg_write_en   = 1'b1;
            reg_write_addr = rd;
         end
         OP_JAL: begin
            reg_write_en   = 1'b1;
            reg_write_addr = ADDR_W'(LINK_REG);
         end
         default: begin
            reg_write_en   = 1'b0;
            reg_write_addr = '0;
         end
      endcase
   end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: per-GPR countdown of cycles until a result is
// forwardable, raising stall on RAW hazards. Define REG_SB_STAT_EN for stall_cycles.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned ALU_LAT  = 0,
   parameter int unsigned CNT_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_valid,
   input  logic [INST_OP_BUS_W-1:0] op,
   input  logic [ADDR_W-1:0]        rs,
   input  logic [ADDR_W-1:0]        rt,
   input  logic [ADDR_W-1:0]        rd,
   input  logic                     flush,
   output logic                     reg_read_en_1,
   output logic                     reg_read_en_2,
   output logic [ADDR_W-1:0]        reg_addr_1,
   output logic [ADDR_W-1:0]        reg_addr_2,
   output logic                     reg_write_en,
   output logic [ADDR_W-1:0]        reg_write_addr,
   output logic                     stall,
`ifdef REG_SB_STAT_EN
   output logic                     issue,
   output logic [31:0]              stall_cycles
`else
   output logic                     issue
`endif
);

   localparam int unsigned     NUM_REGS = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
   localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);

   logic [CNT_W-1:0] cnt [NUM_REGS];
   logic             is_load;
   logic             pend_1;
   logic             pend_2;
   logic             alloc;
   logic [CNT_W-1:0] alloc_cnt;

   reg_decode #(
      .ADDR_W (ADDR_W)
   ) u_decode (
      .op             (op),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd),
      .reg_read_en_1  (reg_read_en_1),
      .reg_read_en_2  (reg_read_en_2),
      .reg_addr_1     (reg_addr_1),
      .reg_addr_2     (reg_addr_2),
      .reg_write_en   (reg_write_en),
      .reg_write_addr (reg_write_addr),
      .is_load        (is_load)
   );

   // Hazard lookup uses the pre-edge counters, so an instruction never waits on its own write.
   assign pend_1 = reg_read_en_1 && (cnt[reg_addr_1] != '0);
   assign pend_2 = reg_read_en_2 && (cnt[reg_addr_2] != '0);
   assign stall  = issue_valid && (pend_1 || pend_2);
   assign issue  = issue_valid && !stall && !flush;

   assign alloc     = issue && reg_write_en && (reg_write_addr != '0);
   assign alloc_cnt = is_load ? LOAD_CNT : ALU_CNT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         cnt[0] <= '0;
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
               cnt[r] <= '0;
            end else if (alloc && (reg_write_addr == ADDR_W'(r))) begin
               cnt[r] <= alloc_cnt;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - CNT_W'(1);
            end
         end
      end
   end

`ifdef REG_SB_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: two instances (default latencies and
// LOAD_LAT=2/ALU_LAT=1) share stimulus and are compared against a ready-cycle model.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          issue_valid;
   logic          flush;
   logic [5:0]    op;
   logic [AW-1:0] rs, rt, rd;

   logic          a_re1, a_re2, a_we, a_stall, a_issue;
   logic [AW-1:0] a_ra1, a_ra2, a_wa;
   logic          b_re1, b_re2, b_we, b_stall, b_issue;
   logic [AW-1:0] b_ra1, b_ra2, b_wa;
`ifdef REG_SB_STAT_EN
   logic [31:0]   a_sc, b_sc;
`endif

   always #5 clk = ~clk;

   reg_scoreboard #(.ADDR_W(AW), .LOAD_LAT(1), .ALU_LAT(0), .CNT_W(2)) u_a (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .op(op),
      .rs(rs), .rt(rt), .rd(rd), .flush(flush),
      .reg_read_en_1(a_re1), .reg_read_en_2(a_re2),
      .reg_addr_1(a_ra1), .reg_addr_2(a_ra2),
      .reg_write_en(a_we), .reg_write_addr(a_wa),
      .stall(a_stall),
`ifdef REG_SB_STAT_EN
      .stall_cycles(a_sc),
`endif
      .issue(a_issue)
   );

   reg_scoreboard #(.ADDR_W(AW), .LOAD_LAT(2), .ALU_LAT(1), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .op(op),
      .rs(rs), .rt(rt), .rd(rd), .flush(flush),
      .reg_read_en_1(b_re1), .reg_read_en_2(b_re2),
      .reg_addr_1(b_ra1), .reg_addr_2(b_ra2),
      .reg_write_en(b_we), .reg_write_addr(b_wa),
      .stall(b_stall),
`ifdef REG_SB_STAT_EN
      .stall_cycles(b_sc),
`endif
      .issue(b_issue)
   );

   // Model: a register is pending while the current cycle is before its ready cycle.
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rdy_a [32];
   int rdy_b [32];
   int sc_a    = 0;
   int sc_b    = 0;

   typedef struct {
      bit r1, r2, w, ld;
      int a1, a2, wa;
   } mdec_t;

   function automatic mdec_t mdec(input logic [5:0] o, input int s, input int t, input int d);
      mdec_t m = '{default: 0};
      m.r2 = o inside {OP_BEQ, OP_BNE, OP_SB, OP_SW, OP_SPECIAL};
      m.r1 = m.r2 || (o inside {OP_ADDIU, OP_ADDI, OP_ANDI, OP_ORI, OP_LB, OP_LW, OP_LBU});
      m.a1 = m.r1 ? s : 0;
      m.a2 = m.r2 ? t : 0;
      m.ld = o inside {OP_LB, OP_LBU, OP_LW};
      if (m.ld || (o inside {OP_ADDIU, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI})) begin
         m.w = 1; m.wa = t;
      end else if (o == OP_SPECIAL) begin
         m.w = 1; m.wa = d;
      end else if (o == OP_JAL) begin
         m.w = 1; m.wa = 31;
      end
      return m;
   endfunction

   function automatic bit mpend(input bit sel_b, input int r);
      return (r != 0) && (cyc < (sel_b ? rdy_b[r] : rdy_a[r]));
   endfunction

   // {re1, re2, ra1, ra2, we, wa, stall, issue}
   function automatic logic [19:0] exp_vec(input bit sel_b);
      mdec_t m = mdec(op, int'(rs), int'(rt), int'(rd));
      bit st = issue_valid && ((m.r1 && mpend(sel_b, m.a1)) || (m.r2 && mpend(sel_b, m.a2)));
      bit is = issue_valid && !st && !flush;
      return {m.r1, m.r2, AW'(m.a1), AW'(m.a2), m.w, AW'(m.wa), st, is};
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < 32; r++) begin
         rdy_a[r] = 0;
         rdy_b[r] = 0;
      end
      sc_a = 0;
      sc_b = 0;
   endfunction

   task automatic drive(input bit v, input logic [5:0] o, input int s, input int t,
                        input int d, input bit f);
      issue_valid = v; op = o; rs = AW'(s); rt = AW'(t); rd = AW'(d); flush = f;
      #2;
   endtask

   task automatic tick();
      mdec_t       m  = mdec(op, int'(rs), int'(rt), int'(rd));
      logic [19:0] ea = exp_vec(1'b0);
      logic [19:0] eb = exp_vec(1'b1);
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         if (ea[1]) sc_a++;
         if (eb[1]) sc_b++;
         if (flush) begin
            for (int r = 0; r < 32; r++) begin
               rdy_a[r] = 0;
               rdy_b[r] = 0;
            end
         end else if (m.w && m.wa != 0) begin
            if (ea[0]) rdy_a[m.wa] = cyc + 1 + (m.ld ? 1 : 0);
            if (eb[0]) rdy_b[m.wa] = cyc + 1 + (m.ld ? 2 : 1);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      drive(0, OP_LW, 8, 8, 0, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_during: got %b want 0000", {a_stall, a_issue, b_stall, b_issue});
      end
      n_tests++;
      if ({a_re1, a_ra1, a_re2, a_ra2, a_we, a_wa} !== {1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8}) begin
         n_fail++;
         $display("FAIL reset_decode: got %h", {a_re1, a_ra1, a_re2, a_ra2, a_we, a_wa});
      end
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      tick();
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 0000", {a_stall, a_issue, b_stall, b_issue});
      end
      // every entry empty: no SW reading any register pair may stall
      for (int r = 0; r < 32; r++) begin
         drive(1, OP_SW, r, 31 - r, 0, 0);
         n_tests++;
         if ({a_stall, b_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_empty r%0d: got stall %b want 00", r, {a_stall, b_stall});
         end
      end
      drive(0, OP_J, 0, 0, 0, 0);
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, OP_LW, 0, 8, 0, 0);
      n_tests++;
      if ({a_stall, a_issue} !== 2'b01) begin
         n_fail++; $display("FAIL lu_issue_lw: got %b want 01", {a_stall, a_issue});
      end
      tick();
      drive(1, OP_SPECIAL, 8, 0, 3, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b1010) begin
         n_fail++; $display("FAIL lu_cycle1: got %b want 1010", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0110) begin
         n_fail++; $display("FAIL lu_cycle2: got %b want 0110", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      n_tests++;
      if ({b_stall, b_issue} !== 2'b01) begin
         n_fail++; $display("FAIL lu_cycle3_b: got %b want 01", {b_stall, b_issue});
      end
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, OP_ADDIU, 1, 9, 0, 0);
      n_tests++;
      if ({a_issue, b_issue} !== 2'b11) begin
         n_fail++; $display("FAIL b2b_addiu: got %b want 11", {a_issue, b_issue});
      end
      tick();
      drive(1, OP_BEQ, 9, 9, 0, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0110) begin
         n_fail++; $display("FAIL b2b_beq: got %b want 0110", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reg0();
      do_reset();
      drive(1, OP_LW, 0, 0, 0, 0);
      tick();
      drive(1, OP_SW, 0, 0, 0, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0101) begin
         n_fail++; $display("FAIL r0_sw: got %b want 0101", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      drive(1, OP_JAL, 0, 0, 0, 0);
      n_tests++;
      if ({a_we, a_wa, a_re1, a_re2} !== {1'b1, 5'd31, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL r0_jal_decode: got %h", {a_we, a_wa, a_re1, a_re2});
      end
      tick();
      drive(1, OP_SPECIAL, 31, 0, 2, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0110) begin
         n_fail++; $display("FAIL r0_link_c1: got %b want 0110", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      n_tests++;
      if ({b_stall, b_issue} !== 2'b01) begin
         n_fail++; $display("FAIL r0_link_c2: got %b want 01", {b_stall, b_issue});
      end
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      drive(1, OP_LW, 0, 5, 0, 0);
      tick();
      drive(1, OP_SPECIAL, 5, 0, 4, 1);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b1010) begin
         n_fail++; $display("FAIL flush_cycle: got %b want 1010", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      drive(1, OP_SPECIAL, 5, 0, 4, 0);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0101) begin
         n_fail++; $display("FAIL flush_after: got %b want 0101", {a_stall, a_issue, b_stall, b_issue});
      end
      drive(1, OP_ADDIU, 1, 6, 0, 1);
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0000) begin
         n_fail++; $display("FAIL flush_nohaz: got %b want 0000", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [5:0]  ops [15] = '{OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                OP_ANDI, OP_ORI, OP_LUI, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW};
      logic [19:0] ea, eb;
      int          f [3];
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 3; k++) f[k] = ($urandom_range(7) == 0) ? 31 : int'($urandom_range(7));
         drive($urandom_range(9) < 8,
               ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(14)],
               f[0], f[1], f[2], $urandom_range(11) == 0);
         ea = exp_vec(1'b0);
         eb = exp_vec(1'b1);
         n_tests++;
         if ({a_re1, a_re2, a_ra1, a_ra2, a_we, a_wa, a_stall, a_issue} !== ea ||
             {b_re1, b_re2, b_ra1, b_ra2, b_we, b_wa, b_stall, b_issue} !== eb) begin
            n_fail++;
            $display("FAIL random cyc %0d op %h: a got %h want %h, b got %h want %h", cyc, op,
                     {a_re1, a_re2, a_ra1, a_ra2, a_we, a_wa, a_stall, a_issue}, ea,
                     {b_re1, b_re2, b_ra1, b_ra2, b_we, b_wa, b_stall, b_issue}, eb);
         end
`ifdef REG_SB_STAT_EN
         n_tests++;
         if (a_sc !== 32'(sc_a) || b_sc !== 32'(sc_b)) begin
            n_fail++;
            $display("FAIL random_stat: got %0d/%0d want %0d/%0d", a_sc, b_sc, sc_a, sc_b);
         end
`endif
         tick();
      end
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1, OP_LW, 0, 8, 0, 0);
      tick();
      drive(1, OP_SPECIAL, 8, 0, 3, 0);
      n_tests++;
      if ({a_stall, b_stall} !== 2'b11) begin
         n_fail++; $display("FAIL arst_pre: got %b want 11", {a_stall, b_stall});
      end
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      n_tests++;
      if ({a_stall, b_stall} !== 2'b00) begin
         n_fail++; $display("FAIL arst_now: got %b want 00", {a_stall, b_stall});
      end
`ifdef REG_SB_STAT_EN
      n_tests++;
      if (a_sc !== 32'd0 || b_sc !== 32'd0) begin
         n_fail++; $display("FAIL arst_stat: got %0d/%0d want 0/0", a_sc, b_sc);
      end
`endif
      tick();
      rst_n = 1'b1;
      #1;
      n_tests++;
      if ({a_stall, a_issue, b_stall, b_issue} !== 4'b0101) begin
         n_fail++; $display("FAIL arst_release: got %b want 0101", {a_stall, a_issue, b_stall, b_issue});
      end
      tick();
      drive(0, OP_J, 0, 0, 0, 0);
      tick();
   endtask

`ifdef REG_SB_STAT_EN
   task automatic test_stats();
      do_reset();
      repeat (3) begin
         drive(1, OP_LW, 0, 8, 0, 0);
         tick();
         drive(1, OP_SPECIAL, 8, 0, 3, 0);
         tick();
         tick();
         drive(0, OP_J, 0, 0, 0, 0);
         tick();
      end
      n_tests++;
      if (a_sc !== 32'd3 || b_sc !== 32'd6) begin
         n_fail++; $display("FAIL stats_count: got %0d/%0d want 3/6", a_sc, b_sc);
      end
   endtask
`endif

   initial begin
      model_clear();
      rst_n = 1'b0;
      drive(0, OP_J, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_back_to_back();
      test_reg0();
      test_flush();
      test_async_reset();
`ifdef REG_SB_STAT_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
